add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq.sv | 132 +++++++++++++
 tb/tb_add_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/add_seq.sv
// add_seq: multi-byte adder that shares one external 8-bit adder between two
// requesters. One operation is accepted at a time with round-robin
// arbitration. Bytes are processed least-significant first, one per cycle,
// and the carry is chained through an internal register.
module add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [8*NBYTES-1:0] a0,
  input  logic [8*NBYTES-1:0] b0,
  input  logic [8*NBYTES-1:0] a1,
  input  logic [8*NBYTES-1:0] b1,
  input  logic                ci0,
  input  logic                ci1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_ci,
  input  logic [8:0]          add_out,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                co,
  output logic                owner
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;          // byte currently on the shared adder
  logic          carry;        // carry chained between bytes
  logic [W-1:0]  opa, opb;     // operands captured at acceptance
  logic          last_served;  // requester served most recently
  logic          pick;         // arbitration winner this cycle
  logic          accept;       // IDLE edge that starts a new operation

  // Round-robin choice: on a tie the requester not served last wins.
  always_comb begin
    if (req0 && req1) pick = ~last_served;
    else              pick = req1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, grant and done decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nx = state;
    accept   = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // idx is cleared at acceptance, so idx==0 marks the first RUN cycle.
        gnt0 = (idx == '0) && !owner;
        gnt1 = (idx == '0) &&  owner;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Drive the current operand byte to the shared adder; zero when not running.
  always_comb begin
    add_a  = 8'h00;
    add_b  = 8'h00;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_ci = carry;
      for (int i = 0; i < NBYTES; i++) begin
        if (idx == IW'(i)) begin
          add_a = opa[8*i +: 8];
          add_b = opb[8*i +: 8];
        end
      end
    end
  end

  // Operand capture, byte-serial accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      carry       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      sum         <= '0;
      co          <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;  // makes requester 0 win the first tie
    end else if (accept) begin
      owner       <= pick;
      last_served <= pick;
      opa         <= pick ? a1  : a0;
      opb         <= pick ? b1  : b0;
      carry       <= pick ? ci1 : ci0;
      idx         <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx == IW'(i)) sum[8*i +: 8] <= add_out[7:0];
      end
      carry <= add_out[8];
      idx   <= idx + IW'(1);
      if (idx == LAST) co <= add_out[8];
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Directed testbench for add_seq: a 4-byte instance and a 1-byte instance,
// each with its own behavioural 8-bit adder on the shared-adder port.
module tb_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-byte instance
  logic        req0, req1, ci0, ci1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, add_ci, done, co, owner;
  logic [7:0]  add_a, add_b;
  logic [8:0]  add_out;
  logic [31:0] sum;

  assign add_out = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_ci};

  add_seq #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ci0(ci0), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_out(add_out), .done(done), .sum(sum), .co(co), .owner(owner)
  );

  // 1-byte instance
  logic       s_req0, s_req1, s_ci0, s_ci1;
  logic [7:0] s_a0, s_b0, s_a1, s_b1;
  logic       s_gnt0, s_gnt1, s_add_ci, s_done, s_co, s_owner;
  logic [7:0] s_add_a, s_add_b, s_sum;
  logic [8:0] s_add_out;

  assign s_add_out = {1'b0, s_add_a} + {1'b0, s_add_b} + {8'b0, s_add_ci};

  add_seq #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(s_req0), .req1(s_req1),
    .a0(s_a0), .b0(s_b0), .a1(s_a1), .b1(s_b1), .ci0(s_ci0), .ci1(s_ci1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .add_a(s_add_a), .add_b(s_add_b),
    .add_ci(s_add_ci), .add_out(s_add_out), .done(s_done), .sum(s_sum),
    .co(s_co), .owner(s_owner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a grant appears; check which one and how many edges it took.
  task automatic wait_gnt(input string tag, input logic who, input int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(gnt0 || gnt1) && n < 12);
    check({tag, "_gnt"}, {62'd0, gnt1, gnt0}, who ? 64'd2 : 64'd1);
    check({tag, "_gntwait"}, 64'(n), 64'(exp_n));
  endtask

  // Step until done (bounded); check latency and the reported result.
  task automatic run_op(input string tag, input int exp_lat, input logic exp_owner,
                        input logic [31:0] exp_sum, input logic exp_co);
    int lat = 0;
    while (!done && lat < 12) begin
      step();
      lat++;
    end
    check({tag, "_lat"},   64'(lat),   64'(exp_lat));
    check({tag, "_done"},  64'(done),  64'd1);
    check({tag, "_sum"},   64'(sum),   64'(exp_sum));
    check({tag, "_co"},    64'(co),    64'(exp_co));
    check({tag, "_owner"}, 64'(owner), 64'(exp_owner));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    rst = 1'b1;
    req0 = 0; req1 = 0; ci0 = 0; ci1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    s_req0 = 0; s_req1 = 0; s_ci0 = 0; s_ci1 = 0;
    s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
    step();
    step();

    // Reset state
    check("rst_outs", {gnt0, gnt1, done, co, owner, add_ci, add_a, add_b, sum},
          64'd0);

    // Single requester 0: 0xFF + 0x01
    rst = 1'b0;
    req0 = 1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; ci0 = 0;
    wait_gnt("r0", 1'b0, 1);
    check("r0_byte0", {47'd0, add_ci, add_a, add_b}, {47'd0, 1'b0, 8'hFF, 8'h01});
    req0 = 0;
    step();
    check("r0_gnt_pulse", {62'd0, gnt1, gnt0}, 64'd0);
    check("r0_byte1", {47'd0, add_ci, add_a, add_b}, {47'd0, 1'b1, 8'h00, 8'h00});
    run_op("r0", 3, 1'b0, 32'h0000_0100, 1'b0);
    step();
    check("r0_idle", {done, add_ci, add_a, add_b, sum}, {19'd0, 32'h0000_0100});

    // Single requester 1 with carry-in: carry ripples through every byte
    req1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0000; ci1 = 1;
    wait_gnt("r1", 1'b1, 1);
    req1 = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r1_ci%0d", k), {62'd0, add_ci, done}, 64'd2);
      step();
    end
    check("r1_done", 64'(done),  64'd1);
    check("r1_sum",  64'(sum),   64'h0);
    check("r1_co",   64'(co),    64'd1);
    check("r1_own",  64'(owner), 64'd1);

    // Both requests held from reset: grants alternate starting at 0
    rst = 1'b1;
    req0 = 1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; ci0 = 0;
    req1 = 1; a1 = 32'h8000_0000; b1 = 32'h8000_0001; ci1 = 1;
    step();
    step();
    check("rr_rst", {sum, co, owner, done}, 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) begin
        wait_gnt($sformatf("rr%0d", j), 1'b0, (j == 0) ? 1 : 2);
        run_op($sformatf("rr%0d", j), 4, 1'b0, 32'h2345_6789, 1'b0);
      end else begin
        wait_gnt($sformatf("rr%0d", j), 1'b1, 2);
        run_op($sformatf("rr%0d", j), 4, 1'b1, 32'h0000_0002, 1'b1);
      end
    end

    // Reset two cycles into RUN aborts the operation
    req0 = 0; req1 = 0;
    step();
    req0 = 1; a0 = 32'h0101_0101; b0 = 32'h0101_0101; ci0 = 0;
    wait_gnt("ab", 1'b0, 1);
    req0 = 0;
    step();
    step();
    check("ab_partial", 64'(sum), 64'h0000_0202);
    rst = 1'b1;
    #1;
    check("ab_rst_outs", {gnt0, gnt1, done, co, owner, add_ci, add_a, add_b, sum},
          64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) rst = 1'b0;
      step();
      if (done) seen_done = 1'b1;
    end
    check("ab_no_done", 64'(seen_done), 64'd0);
    req0 = 1;
    wait_gnt("ab2", 1'b0, 1);
    req0 = 0;
    run_op("ab2", 4, 1'b0, 32'h0202_0202, 1'b0);

    // Operands scrambled during RUN must not affect the result
    step();
    req0 = 1; a0 = 32'h0F0F_0F0F; b0 = 32'h0102_0304; ci0 = 1;
    wait_gnt("hold", 1'b0, 1);
    req0 = 0;
    for (int k = 0; k < 4; k++) begin
      a0 = $urandom; b0 = $urandom; ci0 = 1'($urandom);
      a1 = $urandom; b1 = $urandom; ci1 = 1'($urandom);
      step();
    end
    check("hold_done", 64'(done),  64'd1);
    check("hold_sum",  64'(sum),   64'h1011_1214);
    check("hold_co",   64'(co),    64'd0);
    check("hold_own",  64'(owner), 64'd0);

    // One-byte instance: 0x80 + 0x80
    s_req0 = 1; s_a0 = 8'h80; s_b0 = 8'h80; s_ci0 = 0;
    step();
    check("nb1_gnt", {62'd0, s_gnt1, s_gnt0}, 64'd1);
    check("nb1_opnd", {48'd0, s_add_a, s_add_b}, {48'd0, 8'h80, 8'h80});
    s_req0 = 0;
    step();
    check("nb1_res", {60'd0, s_done, s_co, s_owner, s_gnt0}, 64'hC);
    check("nb1_sum", 64'(s_sum), 64'h0);
    step();
    check("nb1_idle", {62'd0, s_done, s_co}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
